// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words from instruction
// memory over a req/ack handshake, buffers them in a small prefetch FIFO and
// presents the head entry to the datapath. A taken branch (PCSrc) flushes the
// FIFO and discards any word still in flight for the old path.
//
// Handshakes:
//   memory side   - imem_req/imem_addr are held unchanged until imem_ack; a
//                   word transfers in any cycle with imem_req && imem_ack.
//   datapath side - the head entry transfers in any cycle with
//                   inst_valid && inst_ready; inst_ready alone is ignored.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic [31:0]              Instruc,
    output logic [31:0]              PCCur,
    output logic [31:0]              PCAdd,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    input  logic                     PCSrc,
    input  logic [31:0]              ASA,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // RUN: no request outstanding; REQ: request outstanding, its word is kept;
    // DROP: request outstanding, its word belongs to a squashed path.
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_REQ = 2'd1, ST_DROP = 2'd2} state_t;

    state_t          state;
    logic            run_en;
    logic [31:0]     fetch_pc;
    logic [31:0]     req_addr;
    logic [31:0]     last_pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic            pop;
    logic            space;
    logic            xfer;
    logic            push;
    logic [CW-1:0]   count_next;
    logic            space_next;
    logic [31:0]     pc_inc;
    logic [31:0]     target;

    // Handshake decode: request is combinational so it can issue in the same
    // cycle a pop frees a slot; a redirect in RUN suppresses the stale request.
    always_comb begin
        inst_valid = (count != '0);
        pop        = inst_ready && inst_valid;
        space      = (count < DEPTH_C) || pop;
        imem_req   = run_en && ((state != ST_RUN) || (space && !PCSrc));
        imem_addr  = (state == ST_RUN) ? fetch_pc : req_addr;
        xfer       = imem_req && imem_ack;
        push       = xfer && (state != ST_DROP) && !PCSrc;
        count_next = count + CW'(push) - CW'(pop);
        space_next = (count_next < DEPTH_C);
        pc_inc     = fetch_pc + 32'd4;
        target     = {ASA[31:2], 2'b00};
    end

    // Head presentation: a NOP with the last consumed PC when the FIFO is empty.
    always_comb begin
        Instruc    = inst_valid ? data_mem[rd_ptr] : 32'd0;
        PCCur      = inst_valid ? pc_mem[rd_ptr] : last_pc;
        PCAdd      = PCCur + 32'd4;
        fifo_count = count;
        dbg_state  = state;
    end

    // FIFO storage; entries need no reset because count gates their visibility.
    always_ff @(posedge Clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= imem_rdata;
        end
    end

    // Fetch FSM, fetch PC and FIFO bookkeeping; redirect outranks everything.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= ST_RUN;
            run_en   <= 1'b0;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            last_pc  <= 32'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            run_en <= 1'b1;
            if (pop) begin
                last_pc <= pc_mem[rd_ptr];
            end
            if (PCSrc) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= target;
                if (imem_req && !imem_ack) begin
                    state <= ST_DROP;
                end else if (xfer) begin
                    state    <= ST_REQ;
                    req_addr <= target;
                end else begin
                    state <= ST_RUN;
                end
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                count <= count_next;
                if (xfer) begin
                    if (state != ST_DROP) begin
                        fetch_pc <= pc_inc;
                    end
                    if (space_next) begin
                        state    <= ST_REQ;
                        req_addr <= (state == ST_DROP) ? fetch_pc : pc_inc;
                    end else begin
                        state <= ST_RUN;
                    end
                end else if (imem_req && (state == ST_RUN)) begin
                    state    <= ST_REQ;
                    req_addr <= fetch_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory model, datapath consumer, and a
// scoreboard of expected head PCs checked whenever the datapath consumes.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] Instruc;
    logic [31:0] PCCur;
    logic [31:0] PCAdd;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] ASA = 32'd0;
    logic [1:0]  fifo_count;
    logic [1:0]  dbg_state;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .Clk(Clk), .Rst(Rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instruc(Instruc), .PCCur(PCCur), .PCAdd(PCAdd),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .PCSrc(PCSrc), .ASA(ASA),
        .fifo_count(fifo_count), .dbg_state(dbg_state)
    );

    // clock
    always #5 Clk = ~Clk;

    // scoreboard and reference state
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          waits    = 0;
    int          req_age  = 0;
    int          acks     = 0;
    int          cyc      = 0;
    int          last_pop = -1;
    int          n_after  = 0;
    bit          spacing_chk = 1'b0;
    bit          post_redir  = 1'b0;
    bit          dropping    = 1'b0;
    logic [31:0] exp_cur;
    logic [31:0] exp_fetch;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reset (possibly mid-cycle, mid-request) with a stray ack that must be ignored.
    task automatic do_reset();
        @(negedge Clk);
        #2;
        Rst = 1'b0;
        imem_ack = 1'b1;
        inst_ready = 1'b1;
        PCSrc = 1'b0;
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_instruc", Instruc, 32'd0);
        check("rst_pccur", PCCur, 32'd0);
        check("rst_pcadd", PCAdd, 32'd4);
        check("rst_count", {30'd0, fifo_count}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge Clk);
        check("rst_hold_req", {31'd0, imem_req}, 32'd0);
        Rst = 1'b1;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        exp_q.delete();
        exp_cur = RST_PC;
        exp_fetch = RST_PC;
        dropping = 1'b0;
        post_redir = 1'b0;
        req_age = 0;
        acks = 0;
        last_pop = -1;
    endtask

    // One cycle: drive datapath inputs, answer memory, score any consumption.
    task automatic step(input bit ready, input bit redir, input logic [31:0] tgt);
        logic [31:0] e;
        logic [31:0] t;
        @(negedge Clk);
        inst_ready = ready;
        PCSrc = redir;
        ASA = tgt;
        imem_ack = 1'b0;
        #1;
        if (post_redir) check("valid_after_redir", {31'd0, inst_valid}, 32'd0);
        post_redir = 1'b0;
        if (imem_req) begin
            imem_ack = (req_age == waits);
            imem_rdata = mem_word(imem_addr);
            check("req_addr", imem_addr, exp_cur);
        end
        #1;
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", PCCur, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check("pccur", PCCur, e);
                check("instruc", Instruc, mem_word(e));
                check("pcadd", PCAdd, e + 32'd4);
                if (spacing_chk && last_pop >= 0) check("pop_spacing", cyc - last_pop, waits + 1);
                last_pop = cyc;
            end
        end
        if (redir) begin
            t = {tgt[31:2], 2'b00};
            exp_q.delete();
            for (int i = 0; i < n_after; i++) exp_q.push_back(t + 32'(4 * i));
            post_redir = 1'b1;
            if (imem_req && !imem_ack) begin
                dropping = 1'b1;
                exp_fetch = t;
            end else begin
                dropping = 1'b0;
                exp_fetch = t;
                exp_cur = t;
            end
        end else if (imem_req && imem_ack) begin
            if (dropping) begin
                dropping = 1'b0;
                exp_cur = exp_fetch;
            end else begin
                exp_fetch = exp_fetch + 32'd4;
                exp_cur = exp_fetch;
            end
            acks++;
        end
        req_age = (imem_req && !imem_ack) ? req_age + 1 : 0;
        cyc++;
    endtask

    task automatic run_scenario(input int w, input int n_init, input int stall,
                                input int redir_acks, input int redir_age,
                                input logic [31:0] tgt, input int n_post);
        int k;
        bit fired;
        bit rd;
        waits = w;
        n_after = n_post;
        spacing_chk = (stall == 0) && (redir_acks < 0);
        for (int i = 0; i < n_init; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        k = 0;
        fired = 1'b0;
        while (!(exp_q.size() == 0 && (redir_acks < 0 || fired)) && k < 300) begin
            if (stall > 0 && k == stall) begin
                check("stall_count", {30'd0, fifo_count}, 32'd2);
                check("stall_req", {31'd0, imem_req}, 32'd0);
            end
            rd = (redir_acks >= 0) && !fired && (acks == redir_acks) && (req_age == redir_age);
            if (rd) fired = 1'b1;
            step(k >= stall, rd, tgt);
            k++;
        end
        check("scenario_drained", exp_q.size(), 32'd0);
        if (redir_acks >= 0) check("redirect_fired", {31'd0, fired}, 32'd1);
    endtask

    initial begin
        // zero-wait streaming, one per cycle, PC wrap through zero
        do_reset();
        run_scenario(0, 8, 0, -1, 0, 32'd0, 0);
        // three wait states: one word every four cycles, stable address
        do_reset();
        run_scenario(3, 5, 0, -1, 0, 32'd0, 0);
        // consumer stalled: FIFO fills, requests stop, order preserved
        do_reset();
        run_scenario(0, 8, 10, -1, 0, 32'd0, 0);
        // redirect while third request is unacked: its word is dropped
        do_reset();
        run_scenario(3, 8, 0, 2, 1, 32'h0000_0100, 4);
        // redirect in the ack cycle with unaligned target
        do_reset();
        run_scenario(1, 8, 0, 1, 1, 32'h0000_0203, 3);
        // reset in the middle of an outstanding request, then restart
        do_reset();
        waits = 3;
        for (int i = 0; i < 20 && req_age != 2; i++) step(1'b1, 1'b0, 32'd0);
        check("mid_req_reached", req_age, 32'd2);
        do_reset();
        exp_q.delete();
        run_scenario(0, 4, 0, -1, 0, 32'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake with variable wait states.
- Buffers returned words in a small prefetch FIFO and presents the head entry to the datapath as Instruc/PCAdd.
- Redirects on PCSrc using branch target ASA, flushing the FIFO and discarding stale in-flight data.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, prefetch FIFO entries; power of 2, minimum 2.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request; held until ack.
- imem_addr  output  32  word address of the request; low 2 bits always 0.
- imem_ack  input  1  request complete; imem_rdata valid in the same cycle.
- imem_rdata  input  32  instruction word.
- Instruc  output  32  head instruction.
- PCCur  output  32  PC of the head instruction.
- PCAdd  output  32  PCCur + 4.
- inst_valid  output  1  head entry valid.
- inst_ready  input  1  datapath consumes the head this cycle.
- PCSrc  input  1  redirect strobe (taken branch).
- ASA  input  32  redirect target; low 2 bits ignored and forced to 0.
- fifo_count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (Rst=0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty, state RUN.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, Instruc=0, PCCur=0, PCAdd=4, fifo_count=0.
- First request: imem_req rises in the first cycle after Rst deasserts.
- States:
  - RUN (no request outstanding):
    - If fifo_count<DEPTH, or a pop occurs this cycle, assert imem_req with imem_addr=fetch_pc and go to REQ.
    - Request assertion is combinational from state and count, so a request can issue in the same cycle space becomes available.
  - REQ:
    - imem_req=1; imem_addr stable until imem_ack.
    - On ack: push {fetch_pc, imem_rdata}; fetch_pc+=4 (mod 2^32).
    - After ack: issue the next request back-to-back if space remains after this cycle's push/pop, otherwise return to RUN.
  - DROP: entered on a redirect while a request is unacked.
    - imem_req and the old address stay held (handshake rule: address never changes mid-request).
    - On ack, the data is discarded and the next request uses the redirect target.
- Redirect (PCSrc=1) has priority over all other events in that cycle:
  - A pop in the same cycle is honoured: the branch itself is consumed.
  - All other FIFO entries are flushed and fetch_pc<=ASA&~3.
  - If REQ with no ack that cycle: go to DROP.
  - If ack arrives in the redirect cycle: the word is discarded and there is no push.
  - If RUN: the next request targets ASA in the following cycle.
  - Redirect while in DROP: update the pending target; remain in DROP.
  - inst_valid=0 in the cycle after a redirect.
- FIFO:
  - Push and pop in the same cycle are both legal; count is unchanged.
  - Push never occurs when full, because requests only issue with space available.
  - inst_valid=(count!=0).
  - When empty: Instruc=0 (NOP), PCCur holds its last value.
  - Pointers wrap modulo DEPTH.
- Arithmetic: PCAdd=PCCur+4 and fetch_pc+4 are 32-bit with wrap; 32'hFFFF_FFFC+4=0.
- Pop while inst_valid=0 is ignored.
- Reset mid-request: req drops immediately (asynchronously); any later ack is ignored because the state is RUN with req=0.

Test Plan:
- Zero-wait memory (ack same cycle as req), inst_ready=1, RESET_PC=0 → consecutive Instruc words from 0x0,0x4,0x8, one per cycle; PCAdd=PCCur+4.
- Memory with 3 wait states → imem_addr stable across wait cycles; inst_valid pulses once per 4 cycles; no duplicate or skipped PCs.
- inst_ready=0 for 10 cycles → fifo_count saturates at 2; imem_req low after 2 pushes; on release, order preserved (0x0,0x4,0x8...).
- PCSrc=1, ASA=0x100, while request to 0x8 is unacked for 2 more cycles → 0x8 data dropped; next imem_addr=0x100; first valid Instruc after redirect has PCCur=0x100.
- Redirect with ack in the same cycle, plus ASA=0x203 → no push; next request address 0x200.
- Rst pulsed low mid-REQ; fetch from RESET_PC=0xFFFF_FFF8 → outputs at reset values instantly; fetch restarts at RESET_PC; PCs 0xFFFF_FFF8,0xFFFF_FFFC,0x0 with PCAdd wrapping.
